// File: rtl/df_addr_seq.sv
// Address sequencer: emits base..base+len-1 (mod 2^ADDR_W) for reps+1 passes
// over a valid/ready handshake, then pulses done for one cycle.
module df_addr_seq #(
  parameter int ADDR_W = 3,
  parameter int LEN_W  = 4,
  parameter int REP_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              clr,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] base,
  input  logic [REP_W-1:0]  reps,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_vld,
  output logic              last,
  output logic              rep_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_d;
  logic [LEN_W-1:0]   idx, idx_d, idx_inc;
  logic [REP_W-1:0]   rep_cnt, rep_cnt_d, rep_inc;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [REP_W-1:0]   reps_q, reps_d;
  logic [ADDR_W-1:0]  addr_d;
  logic               addr_vld_d, last_d, rep_last_d, busy_d, done_d;

  always_comb begin
    state_d    = state;
    idx_d      = idx;
    rep_cnt_d  = rep_cnt;
    len_d      = len_q;
    base_d     = base_q;
    reps_d     = reps_q;
    addr_d     = addr;
    addr_vld_d = 1'b0;
    last_d     = 1'b0;
    rep_last_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    idx_inc    = idx + 1'b1;
    rep_inc    = rep_cnt + 1'b1;

    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start && (len != '0)) begin
            state_d    = RUN;
            len_d      = len;
            base_d     = base;
            reps_d     = reps;
            idx_d      = '0;
            rep_cnt_d  = '0;
            addr_d     = base;
            addr_vld_d = 1'b1;
            busy_d     = 1'b1;
            last_d     = (len == LEN_W'(1));
            rep_last_d = (reps == '0);
          end else if (start) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
        RUN: begin
          addr_vld_d = 1'b1;
          busy_d     = 1'b1;
          last_d     = last;
          rep_last_d = rep_last;
          if (out_ready) begin
            if (last && rep_last) begin
              state_d    = DONE;
              done_d     = 1'b1;
              addr_vld_d = 1'b0;
              busy_d     = 1'b0;
              last_d     = 1'b0;
              rep_last_d = 1'b0;
            end else if (last) begin
              // Next pass restarts at base with no bubble.
              idx_d      = '0;
              rep_cnt_d  = rep_inc;
              addr_d     = base_q;
              last_d     = (len_q == LEN_W'(1));
              rep_last_d = (rep_inc == reps_q);
            end else begin
              idx_d      = idx_inc;
              addr_d     = base_q + idx_inc[ADDR_W-1:0];
              last_d     = (idx_inc == len_q - LEN_W'(1));
            end
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      rep_cnt  <= '0;
      addr     <= '0;
      addr_vld <= 1'b0;
      last     <= 1'b0;
      rep_last <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      idx      <= idx_d;
      rep_cnt  <= rep_cnt_d;
      addr     <= addr_d;
      addr_vld <= addr_vld_d;
      last     <= last_d;
      rep_last <= rep_last_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  // Sequence parameters are held from the accepted start until the next one.
  always_ff @(posedge clk) begin
    len_q  <= len_d;
    base_q <= base_d;
    reps_q <= reps_d;
  end

endmodule

// File: tb/tb_df_addr_seq.sv
// Bench for df_addr_seq: fixed vector table, directed corner sequences and
// randomized traffic checked against a queue-based expected-address model.
module tb_df_addr_seq;
  localparam int ADDR_W = 3;
  localparam int LEN_W  = 4;
  localparam int REP_W  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0, start = 1'b0, clr = 1'b0, out_ready = 1'b0;
  logic [LEN_W-1:0]  len = '0;
  logic [ADDR_W-1:0] base = '0;
  logic [REP_W-1:0]  reps = '0;
  logic [ADDR_W-1:0] addr;
  logic              addr_vld, last, rep_last, busy, done;

  df_addr_seq #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .REP_W(REP_W)) dut (
    .clk(clk), .reset(reset), .start(start), .clr(clr), .len(len), .base(base),
    .reps(reps), .out_ready(out_ready), .addr(addr), .addr_vld(addr_vld),
    .last(last), .rep_last(rep_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Packed output view: {addr, addr_vld, last, rep_last, busy, done}
  typedef logic [ADDR_W+4:0] obs_t;

  typedef struct {
    logic s, c, r, rdy;
    logic [LEN_W-1:0]  ln;
    logic [ADDR_W-1:0] bs;
    logic [REP_W-1:0]  rp;
    obs_t              exp;
  } row_t;
  row_t tbl[$];

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic l, rl;
  } beat_t;
  beat_t q[$];
  int   m_phase = 0;            // 0 idle, 1 issuing, 2 done pulse
  obs_t m_exp = '0;
  logic [ADDR_W-1:0] m_addr = '0;

  function automatic obs_t dut_obs();
    return {addr, addr_vld, last, rep_last, busy, done};
  endfunction

  task automatic check(input string nm, input obs_t act, input obs_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got {addr,vld,last,rlast,busy,done}=%b_%b, expected %b_%b",
               nm, $time, act[ADDR_W+4:5], act[4:0], exp[ADDR_W+4:5], exp[4:0]);
    end
  endtask

  // Reference: a sequence is the flat list of (address, last, rep_last) beats.
  task automatic model_step(input logic s, c, r, rdy, input logic [LEN_W-1:0] ln,
                            input logic [ADDR_W-1:0] bs, input logic [REP_W-1:0] rp);
    if (r) begin
      q.delete(); m_phase = 0; m_addr = '0;
    end else if (c) begin
      q.delete(); m_phase = 0;
    end else begin
      case (m_phase)
        0: if (s) begin
          if (ln == 0) m_phase = 2;
          else begin
            for (int p = 0; p <= int'(rp); p++)
              for (int i = 0; i < int'(ln); i++)
                q.push_back('{a: ADDR_W'((int'(bs) + i) % (1 << ADDR_W)),
                              l: (i == int'(ln) - 1), rl: (p == int'(rp))});
            m_phase = 1;
          end
        end
        1: if (rdy) begin
          void'(q.pop_front());
          if (q.size() == 0) m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end
    if (m_phase == 1) begin
      m_addr = q[0].a;
      m_exp = {q[0].a, 1'b1, q[0].l, q[0].rl, 1'b1, 1'b0};
    end else begin
      m_exp = {m_addr, 3'b000, 1'b0, m_phase == 2};
    end
  endtask

  task automatic drive(input logic s, c, r, rdy, input logic [LEN_W-1:0] ln,
                       input logic [ADDR_W-1:0] bs, input logic [REP_W-1:0] rp);
    start = s; clr = c; reset = r; out_ready = rdy; len = ln; base = bs; reps = rp;
    @(posedge clk);
    model_step(s, c, r, rdy, ln, bs, rp);
    #1;
  endtask

  task automatic cyc(input string nm, input logic s, c, r, rdy,
                     input logic [LEN_W-1:0] ln, input logic [ADDR_W-1:0] bs,
                     input logic [REP_W-1:0] rp);
    drive(s, c, r, rdy, ln, bs, rp);
    check(nm, dut_obs(), m_exp);
  endtask

  task automatic add(input logic s, c, r, rdy, input int ln, bs, rp,
                     input int ea, input logic ev, el, erl, eb, ed);
    row_t t;
    t.s = s; t.c = c; t.r = r; t.rdy = rdy;
    t.ln = LEN_W'(ln); t.bs = ADDR_W'(bs); t.rp = REP_W'(rp);
    t.exp = {ADDR_W'(ea), ev, el, erl, eb, ed};
    tbl.push_back(t);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    //  s  c  r  rdy len base reps | addr vld last rl busy done
    add(1, 0, 1, 1, 5, 3, 0,   0, 0, 0, 0, 0, 0);   // reset dominates start
    add(1, 0, 0, 1, 0, 5, 2,   0, 0, 0, 0, 0, 1);   // len=0: done, no address
    add(0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 4, 6, 1,   6, 1, 0, 0, 1, 0);   // len4 base6 reps1
    add(1, 0, 0, 1, 0, 1, 0,   7, 1, 0, 0, 1, 0);   // start ignored in RUN
    add(0, 0, 0, 1, 9, 2, 5,   0, 1, 0, 0, 1, 0);   // wrap, new inputs ignored
    add(0, 0, 0, 1, 4, 6, 1,   1, 1, 1, 0, 1, 0);
    add(0, 0, 0, 1, 4, 6, 1,   6, 1, 0, 1, 1, 0);   // second pass, no bubble
    add(0, 0, 0, 1, 4, 6, 1,   7, 1, 0, 1, 1, 0);
    add(0, 0, 0, 1, 4, 6, 1,   0, 1, 0, 1, 1, 0);
    add(0, 0, 0, 1, 4, 6, 1,   1, 1, 1, 1, 1, 0);
    add(1, 0, 0, 1, 4, 6, 1,   1, 0, 0, 0, 0, 1);   // done; start ignored
    add(0, 0, 0, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 3, 2, 0,   2, 1, 0, 1, 1, 0);   // len3 base2 reps0
    add(0, 0, 0, 0, 3, 2, 0,   2, 1, 0, 1, 1, 0);   // stall
    add(0, 0, 0, 0, 3, 2, 0,   2, 1, 0, 1, 1, 0);
    add(0, 0, 0, 1, 3, 2, 0,   3, 1, 0, 1, 1, 0);
    add(0, 0, 0, 1, 3, 2, 0,   4, 1, 1, 1, 1, 0);
    add(0, 0, 0, 0, 3, 2, 0,   4, 1, 1, 1, 1, 0);   // stall on last beat
    add(0, 0, 0, 1, 3, 2, 0,   4, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 3, 2, 0,   4, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 5, 1,   5, 1, 1, 0, 1, 0);   // len1: last every beat
    add(0, 0, 0, 1, 1, 5, 1,   5, 1, 1, 1, 1, 0);
    add(0, 0, 0, 1, 1, 5, 1,   5, 0, 0, 0, 0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].s, tbl[i].c, tbl[i].r, tbl[i].rdy, tbl[i].ln, tbl[i].bs, tbl[i].rp);
      check($sformatf("table[%0d]", i), dut_obs(), tbl[i].exp);
    end
    cyc("idle", 0, 0, 0, 0, 0, 0, 0);

    // Full 8-address pass from 0, then done.
    cyc("seq8_start", 1, 0, 0, 1, 8, 0, 0);
    for (int i = 0; i < 9; i++) cyc($sformatf("seq8[%0d]", i), 0, 0, 0, 1, 8, 0, 0);
    cyc("seq8_idle", 0, 0, 0, 1, 8, 0, 0);

    // len above 2^ADDR_W wraps within a pass.
    cyc("len12_start", 1, 0, 0, 1, 12, 3, 0);
    for (int i = 0; i < 12; i++) cyc($sformatf("len12[%0d]", i), 0, 0, 0, 1, 12, 3, 0);

    // clr with start mid-sequence aborts without done; restart uses new base.
    cyc("clr_start", 1, 0, 0, 1, 6, 1, 2);
    cyc("clr_run", 0, 0, 0, 1, 6, 1, 2);
    cyc("clr_abort", 1, 1, 0, 1, 6, 4, 0);
    cyc("clr_idle", 0, 0, 0, 1, 6, 4, 0);
    cyc("clr_restart", 1, 0, 0, 1, 2, 4, 0);
    cyc("clr_r1", 0, 0, 0, 1, 2, 4, 0);
    cyc("clr_r2", 0, 0, 0, 1, 2, 4, 0);
    cyc("clr_r3", 0, 0, 0, 1, 2, 4, 0);

    // reset at idx=2 of len=8, with start held high.
    cyc("rst_start", 1, 0, 0, 1, 8, 5, 0);
    cyc("rst_i1", 0, 0, 0, 1, 8, 5, 0);
    cyc("rst_i2", 0, 0, 0, 1, 8, 5, 0);
    cyc("rst_hit", 1, 0, 1, 1, 8, 5, 0);
    cyc("rst_hold", 1, 0, 1, 1, 8, 5, 0);
    cyc("rst_after", 0, 0, 0, 1, 8, 5, 0);
    cyc("rst_after2", 0, 0, 0, 1, 8, 5, 0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      logic s, c, r, rdy;
      s   = ($urandom_range(0, 3) == 0);
      c   = ($urandom_range(0, 39) == 0);
      r   = ($urandom_range(0, 79) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      cyc($sformatf("rand[%0d]", i), s, c, r, rdy, LEN_W'($urandom_range(0, 15)),
          ADDR_W'($urandom), REP_W'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/df_addr_seq.md
DF_ADDR_SEQ -- requirements
Module: df_addr_seq

Interface
REQ-001 Parameter ADDR_W, default 3, address width (RAM word address bus).
REQ-002 Parameter LEN_W, default 4, width of pass length; SHALL satisfy LEN_W >= ADDR_W.
REQ-003 Parameter REP_W, default 4, width of repeat count.
REQ-004 clk  in  1  single clock; all state SHALL update on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  request one sequence; sampled only in IDLE.
REQ-007 clr  in  1  synchronous abort; returns to IDLE without done.
REQ-008 len  in  LEN_W  addresses per pass; latched on accepted start.
REQ-009 base  in  ADDR_W  first address of each pass; latched on accepted start.
REQ-010 reps  in  REP_W  extra passes; total passes = reps+1; latched on accepted start.
REQ-011 out_ready  in  1  downstream accepts current address.
REQ-012 addr  out  ADDR_W  current RAM address.
REQ-013 addr_vld  out  1  addr is valid; transfer occurs when addr_vld & out_ready.
REQ-014 last  out  1  current addr is final address of its pass.
REQ-015 rep_last  out  1  current pass is the final pass.
REQ-016 busy  out  1  high in RUN.
REQ-017 done  out  1  one-cycle pulse at sequence completion.

Function
REQ-018 States SHALL be IDLE, RUN, DONE; all outputs registered.
REQ-019 IDLE: start=1, clr=0, len!=0 -> latch len/base/reps, idx=0, rep_cnt=0, next state RUN.
REQ-020 IDLE: start=1, clr=0, len==0 -> next state DONE; no address issued.
REQ-021 Latency: start sampled at edge N -> addr_vld=1, addr=base, busy=1 after edge N.
REQ-022 RUN: addr SHALL equal (base + idx) mod 2^ADDR_W; wrap past 2^ADDR_W-1 to 0 is legal and silent.
REQ-023 RUN: addr_vld SHALL stay 1 and addr/last/rep_last stable while out_ready=0 (no advance, no drop).
REQ-024 RUN: on transfer with idx < len-1 -> idx+1, addr advances next cycle; one address per cycle at full throughput.
REQ-025 last SHALL be 1 exactly when idx == len-1; rep_last exactly when rep_cnt == latched reps.
REQ-026 Transfer with last=1, rep_last=0 -> idx=0, rep_cnt+1, addr=base next cycle, no bubble.
REQ-027 Transfer with last=1, rep_last=1 -> next state DONE, addr_vld=0 next cycle.
REQ-028 DONE: done=1 for exactly one cycle, busy=0, then IDLE unconditionally.
REQ-029 start while RUN or DONE SHALL be ignored; input changes to len/base/reps after latch SHALL have no effect.
REQ-030 clr=1 in any state -> IDLE next cycle, addr_vld=0, busy=0, done=0; clr has priority over start and transfer in the same cycle.
REQ-031 len values above 2^ADDR_W SHALL be honoured (addresses wrap and repeat within the pass).
REQ-032 Outside RUN: addr_vld=0, last=0, rep_last=0; addr holds last value.

Reset
REQ-033 reset=1 at a clock edge -> IDLE, addr=0, addr_vld=0, last=0, rep_last=0, busy=0, done=0, idx=0, rep_cnt=0.
REQ-034 reset SHALL take priority over clr, start and transfer, including mid-sequence; no done pulse follows.

Verification
REQ-035 ADDR_W=3: start, len=8, base=0, reps=0, out_ready=1 -> addr 0..7 on 8 consecutive cycles, last on 7, done 1 cycle after last.
REQ-036 len=4, base=6, reps=1, out_ready=1 -> addr 6,7,0,1,6,7,0,1; last on 4th and 8th; rep_last on final 4; single done.
REQ-037 len=3, base=2, reps=0, out_ready toggled 1,0,0,1,1 -> addr 2 held through stall, sequence 2,3,4 delivered once each.
REQ-038 start with len=0 -> no addr_vld, done=1 one cycle after start, busy never high.
REQ-039 Mid-sequence clr together with start -> IDLE next cycle, no done; following start restarts at base.
REQ-040 reset asserted at idx=2 of len=8 -> all outputs at reset values next cycle; start ignored while reset=1.
